// File: rtl/ps2_stopwatch_ctrl.sv
// PS/2 keyboard front end and IDLE/RUNNING/PAUSED stopwatch command sequencer.
// Define PS2_PARITY_CHECK_EN to drop frames whose odd-parity bit is wrong.
//
// state     | meaning
// ----------+------------------------------------------
// S_IDLE    | stopwatch stopped and cleared, run=0
// S_RUNNING | stopwatch counting, run=1
// S_PAUSED  | stopwatch held at current value, run=0
module ps2_stopwatch_ctrl #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       run,
    output logic       clear,
    output logic [7:0] led,
    output logic [1:0] state,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUNNING = 2'b01,
        S_PAUSED  = 2'b10
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev;
    logic                   fall, bit_in, timeout, parity_ok;
    logic [3:0]             bit_cnt;
    logic [7:0]             shreg, byte_data;
    logic                   par_bit, byte_valid;
    logic [TW-1:0]          to_cnt;
    state_t                 st, st_nxt;
    logic                   clear_nxt, brk, ext;
    logic                   is_make, cmd_start, cmd_pause, cmd_clear;

    // Synchronizers idle high so reset never fabricates a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall    = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_in  = data_sync[SYNC_STAGES-1];
    assign timeout = (bit_cnt != 4'd0) && !fall && (to_cnt == '0);

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^{shreg, par_bit};
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= 4'd0;
            shreg      <= 8'h00;
            par_bit    <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            frame_err  <= 1'b0;
            to_cnt     <= TO_LOAD;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                to_cnt <= TO_LOAD;
                if (bit_cnt == 4'd0) begin
                    if (bit_in) frame_err <= 1'b1;
                    else        bit_cnt   <= 4'd1;
                end else if (bit_cnt <= 4'd8) begin
                    shreg   <= {bit_in, shreg[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (bit_cnt == 4'd9) begin
                    par_bit <= bit_in;
                    bit_cnt <= 4'd10;
                end else begin
                    bit_cnt <= 4'd0;
                    if (bit_in && parity_ok) begin
                        byte_valid <= 1'b1;
                        byte_data  <= shreg;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end else if (timeout) begin
                bit_cnt   <= 4'd0;
                frame_err <= 1'b1;
            end else if (bit_cnt == 4'd0) begin
                to_cnt <= TO_LOAD;
            end else if (to_cnt != '0) begin
                to_cnt <= to_cnt - 1'b1;
            end
        end
    end

    assign is_make   = byte_valid && (byte_data != 8'hF0) && (byte_data != 8'hE0) && !brk && !ext;
    assign cmd_start = is_make && (byte_data == 8'h1B);
    assign cmd_pause = is_make && (byte_data == 8'h4D);
    assign cmd_clear = is_make && (byte_data == 8'h2D);

    always_comb begin
        st_nxt    = st;
        clear_nxt = 1'b0;
        case (st)
            S_IDLE:    if (cmd_start) st_nxt = S_RUNNING;
            S_RUNNING: if (cmd_pause) st_nxt = S_PAUSED;
            S_PAUSED:  if (cmd_start) st_nxt = S_RUNNING;
            default:   st_nxt = S_IDLE;
        endcase
        if (cmd_clear) begin
            st_nxt    = S_IDLE;
            clear_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st    <= S_IDLE;
            run   <= 1'b0;
            clear <= 1'b0;
            led   <= 8'hF0;
            brk   <= 1'b0;
            ext   <= 1'b0;
        end else begin
            st    <= st_nxt;
            run   <= (st_nxt == S_RUNNING);
            clear <= clear_nxt;
            if (byte_valid) begin
                if (byte_data == 8'hF0) begin
                    brk <= 1'b1;
                end else if (byte_data == 8'hE0) begin
                    ext <= 1'b1;
                end else begin
                    // Extended break codes never reach the LEDs.
                    if (brk && !ext) led <= byte_data;
                    brk <= 1'b0;
                    ext <= 1'b0;
                end
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_ps2_stopwatch_ctrl.sv
// Self-checking bench for ps2_stopwatch_ctrl: vector table, corner sequences, random frames vs byte-level model.
module tb_ps2_stopwatch_ctrl;

    localparam int TO_CYC = 200;
    localparam int SYNC   = 2;
    localparam int HALF   = 8;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, ps2_clk, ps2_data;
    logic       run, clear, frame_err;
    logic [7:0] led;
    logic [1:0] state;

    always #5 clk = ~clk;

    ps2_stopwatch_ctrl #(.TIMEOUT_CYC(TO_CYC), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .run(run), .clear(clear), .led(led), .state(state), .frame_err(frame_err)
    );

    int n_pass = 0, n_total = 0;
    int clr_cnt = 0, ferr_cnt = 0, clr_wide = 0, ferr_wide = 0;
    logic clr_q = 1'b0, ferr_q = 1'b0;

    always @(negedge clk) begin
        if (clear) begin
            clr_cnt++;
            if (clr_q) clr_wide++;
        end
        if (frame_err) begin
            ferr_cnt++;
            if (ferr_q) ferr_wide++;
        end
        clr_q  = clear;
        ferr_q = frame_err;
    end

    // Byte-level reference: 0 idle, 1 running, 2 paused.
    int         m_state, m_clr, m_ferr;
    logic [7:0] m_led;
    bit         m_brk, m_ext;

    task automatic model_reset();
        m_state = 0; m_led = 8'hF0; m_brk = 0; m_ext = 0;
    endtask

    task automatic model_byte(input logic [7:0] d, input bit bad);
        if (bad && PAR_EN) begin
            m_ferr++;
        end else if (d == 8'hF0) begin
            m_brk = 1;
        end else if (d == 8'hE0) begin
            m_ext = 1;
        end else begin
            if (m_ext) begin
            end else if (m_brk) begin
                m_led = d;
            end else if (d == 8'h1B) begin
                m_state = 1;
            end else if (d == 8'h4D) begin
                if (m_state != 0) m_state = 2;
            end else if (d == 8'h2D) begin
                m_state = 0;
                m_clr++;
            end
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad);
        return {1'b1, (~^d) ^ bad, d, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] d, input bit bad);
        logic [10:0] f;
        f = mk_frame(d, bad);
        for (int i = 0; i < 11; i++) send_bit(f[i]);
        repeat (20) @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_state"}, int'(state), m_state);
        check({tag, "_run"}, int'(run), int'(m_state == 1));
        check({tag, "_led"}, int'(led), int'(m_led));
        check({tag, "_clears"}, clr_cnt, m_clr);
        check({tag, "_ferrs"}, ferr_cnt, m_ferr);
    endtask

    typedef struct {
        logic [7:0] code;
        bit         bad;
        logic [1:0] st;
        logic [7:0] led;
        int         clr;
        int         ferr;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [10:0] f;
        int c0, f0, lat;
        bit found;
        logic [7:0] pool [8];

        tbl[0]  = '{8'h1B, 0, 2'b01, 8'hF0, 0, 0};
        tbl[1]  = '{8'h4D, 0, 2'b10, 8'hF0, 0, 0};
        tbl[2]  = '{8'h1B, 0, 2'b01, 8'hF0, 0, 0};
        tbl[3]  = '{8'h2D, 0, 2'b00, 8'hF0, 1, 0};
        tbl[4]  = '{8'hF0, 0, 2'b00, 8'hF0, 0, 0};
        tbl[5]  = '{8'h1C, 0, 2'b00, 8'h1C, 0, 0};
        tbl[6]  = '{8'hE0, 0, 2'b00, 8'h1C, 0, 0};
        tbl[7]  = '{8'hF0, 0, 2'b00, 8'h1C, 0, 0};
        tbl[8]  = '{8'h1B, 0, 2'b00, 8'h1C, 0, 0};
        tbl[9]  = '{8'h4D, 0, 2'b00, 8'h1C, 0, 0};
        tbl[10] = '{8'h1B, 1, (PAR_EN ? 2'b00 : 2'b01), 8'h1C, 0, (PAR_EN ? 1 : 0)};
        tbl[11] = '{8'h2D, 0, 2'b00, 8'h1C, 1, 0};

        ps2_clk = 1'b1; ps2_data = 1'b1; reset = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", int'(state), 0);
        check("rst_run", int'(run), 0);
        check("rst_clear", int'(clear), 0);
        check("rst_led", int'(led), 8'hF0);
        check("rst_ferr", int'(frame_err), 0);
        model_reset();
        m_clr = 0; m_ferr = 0;

        for (int i = 0; i < 12; i++) begin
            c0 = clr_cnt; f0 = ferr_cnt;
            send_frame(tbl[i].code, tbl[i].bad);
            model_byte(tbl[i].code, tbl[i].bad);
            check($sformatf("vec%0d_state", i), int'(state), int'(tbl[i].st));
            check($sformatf("vec%0d_run", i), int'(run), int'(tbl[i].st == 2'b01));
            check($sformatf("vec%0d_led", i), int'(led), int'(tbl[i].led));
            check($sformatf("vec%0d_clear", i), clr_cnt - c0, tbl[i].clr);
            check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, tbl[i].ferr);
        end

        // Command latency measured from the stop-bit falling edge on the pin.
        f = mk_frame(8'h1B, 0);
        for (int i = 0; i < 10; i++) send_bit(f[i]);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        lat = 0; found = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (!found && state == 2'b01) begin
                lat = k;
                found = 1;
            end
        end
        check("lat_found", int'(found), 1);
        check("lat_not_early", int'(lat >= 3), 1);
        check("lat_not_late", int'(lat <= 5), 1);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        model_byte(8'h1B, 0);
        check_model("lat");

        // Partial frame abandoned long enough to time out, then a clean frame.
        send_frame(8'h2D, 0);
        model_byte(8'h2D, 0);
        f0 = ferr_cnt;
        f = mk_frame(8'h1B, 0);
        for (int i = 0; i < 5; i++) send_bit(f[i]);
        repeat (TO_CYC + 5) @(negedge clk);
        m_ferr++;
        check("timeout_ferr", ferr_cnt - f0, 1);
        check("timeout_state", int'(state), 0);
        send_frame(8'h1B, 0);
        model_byte(8'h1B, 0);
        check_model("post_timeout");

        // Reset in the middle of a PAUSE frame while running.
        f = mk_frame(8'h4D, 0);
        for (int i = 0; i < 7; i++) send_bit(f[i]);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        model_reset();
        check("midrst_state", int'(state), 0);
        check("midrst_run", int'(run), 0);
        check("midrst_clear", int'(clear), 0);
        check("midrst_led", int'(led), 8'hF0);
        check("midrst_ferr", int'(frame_err), 0);
        send_frame(8'h1B, 0);
        model_byte(8'h1B, 0);
        check_model("post_reset");

        pool[0] = 8'h1B; pool[1] = 8'h4D; pool[2] = 8'h2D; pool[3] = 8'hF0;
        pool[4] = 8'hE0; pool[5] = 8'h1C; pool[6] = 8'h29; pool[7] = 8'h00;
        for (int i = 0; i < 60; i++) begin
            logic [7:0] d;
            bit bad;
            int sel;
            sel = $urandom_range(0, 8);
            d = (sel == 8) ? 8'($urandom_range(0, 255)) : pool[sel];
            bad = ($urandom_range(0, 9) == 0);
            send_frame(d, bad);
            model_byte(d, bad);
            check_model($sformatf("rnd%0d", i));
        end

        check("clear_width", clr_wide, 0);
        check("ferr_width", ferr_wide, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
